// File: rtl/time_pkg.sv
// Shared types and limits for the time_keeper clock core.
package time_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_t;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] HOUR_MAX = 6'd23;

    // Step a field one place up or down, wrapping within 0..max.
    function automatic logic [5:0] wrap_step(input logic [5:0] val,
                                             input logic [5:0] max,
                                             input logic       up);
        if (up) begin
            return (val == max) ? 6'd0 : val + 6'd1;
        end
        return (val == 6'd0) ? max : val - 6'd1;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Button synchroniser, debouncer and rising-edge detector, with optional
// hold-to-repeat stepping when TIME_KEEPER_AUTO_REPEAT_EN is defined.
module btn_conditioner
    import time_pkg::*;
#(
    parameter int DB_CYCLES    = 20000,
    parameter int REPEAT_DELAY = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic ena_5hz,
    input  logic rep_en,
    output logic level,
    output logic press,
    output logic step
);

    localparam int CNT_W = $clog2(DB_CYCLES);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // The counter only runs while the synchronised value disagrees with the
    // accepted level, so any bounce back clears it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync1_q <= btn;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

`ifdef TIME_KEEPER_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_q, rep_d;

    // Count 5 Hz ticks while held; once the delay is reached every tick repeats.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_d     = 1'b0;
        if (!(rep_en && level_q)) begin
            rep_cnt_d = '0;
        end else if (ena_5hz) begin
            if (rep_cnt_q == REP_W'(REPEAT_DELAY)) begin
                rep_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q <= '0;
            rep_q     <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_q     <= rep_d;
        end
    end

    assign step = press_q | rep_q;
`else
    logic unused_repeat_inputs;
    assign unused_repeat_inputs = ena_5hz ^ rep_en ^ (REPEAT_DELAY > 0);
    assign step = press_q;
`endif

endmodule

// File: rtl/time_keeper.sv
// Hours/minutes/seconds core with mode FSM, set-mode editing and 12/24-hour
// display. Optional hold-to-repeat via TIME_KEEPER_AUTO_REPEAT_EN.
module time_keeper
    import time_pkg::*;
#(
    parameter int DB_CYCLES    = 20000,
    parameter int H24          = 1,
    parameter int REPEAT_DELAY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       ena_5hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_dw,
    output logic [1:0] select_mode,
    output logic [5:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       pm
);

    mode_t      mode_q, mode_d;
    logic [5:0] h_q, h_d, m_q, m_d, s_q, s_d;

    logic mode_press, up_step, dw_step, up_level, dw_level, in_set;
    logic unused_mode_level, unused_mode_step, unused_up_press, unused_dw_press;
    logic inc, dec;

    assign in_set = (mode_q != MODE_RUN);

    btn_conditioner #(.DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY)) u_btn_mode (
        .clk(clk), .rst(rst), .btn(btn_mode), .ena_5hz(ena_5hz), .rep_en(1'b0),
        .level(unused_mode_level), .press(mode_press), .step(unused_mode_step)
    );

    // A mode press, or the other button being held, clears/blocks repeating.
    btn_conditioner #(.DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY)) u_btn_up (
        .clk(clk), .rst(rst), .btn(btn_up), .ena_5hz(ena_5hz),
        .rep_en(in_set && !mode_press && !dw_level),
        .level(up_level), .press(unused_up_press), .step(up_step)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY)) u_btn_dw (
        .clk(clk), .rst(rst), .btn(btn_dw), .ena_5hz(ena_5hz),
        .rep_en(in_set && !mode_press && !up_level),
        .level(dw_level), .press(unused_dw_press), .step(dw_step)
    );

    always_comb begin
        mode_d = mode_q;
        if (mode_press) begin
            unique case (mode_q)
                MODE_RUN:      mode_d = MODE_SET_HOUR;
                MODE_SET_HOUR: mode_d = MODE_SET_MIN;
                MODE_SET_MIN:  mode_d = MODE_SET_SEC;
                MODE_SET_SEC:  mode_d = MODE_RUN;
            endcase
        end
    end

    assign inc = up_step && !dw_step;
    assign dec = dw_step && !up_step;

    always_comb begin
        h_d = h_q;
        m_d = m_q;
        s_d = s_q;
        unique case (mode_q)
            MODE_RUN: begin
                if (ena) begin
                    s_d = wrap_step(s_q, SEC_MAX, 1'b1);
                    if (s_q == SEC_MAX) begin
                        m_d = wrap_step(m_q, MIN_MAX, 1'b1);
                        if (m_q == MIN_MAX) begin
                            h_d = wrap_step(h_q, HOUR_MAX, 1'b1);
                        end
                    end
                end
            end
            MODE_SET_HOUR: if (inc || dec) h_d = wrap_step(h_q, HOUR_MAX, inc);
            MODE_SET_MIN:  if (inc || dec) m_d = wrap_step(m_q, MIN_MAX, inc);
            MODE_SET_SEC:  if (inc || dec) s_d = wrap_step(s_q, SEC_MAX, inc);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_RUN;
            h_q    <= '0;
            m_q    <= '0;
            s_q    <= '0;
        end else begin
            mode_q <= mode_d;
            h_q    <= h_d;
            m_q    <= m_d;
            s_q    <= s_d;
        end
    end

    assign select_mode = mode_q;
    assign min         = m_q;
    assign sec         = s_q;

    generate
        if (H24 != 0) begin : g_h24
            assign hour = h_q;
            assign pm   = 1'b0;
        end else begin : g_h12
            // Internal 0 and 12 both display as 12.
            assign hour = (h_q == 6'd0) ? 6'd12 : (h_q > 6'd12) ? h_q - 6'd12 : h_q;
            assign pm   = (h_q >= 6'd12);
        end
    endgenerate

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: one 24-hour and one 12-hour instance
// share stimulus and are compared against a seconds-of-day reference model.
module tb_time_keeper;

    localparam int DB  = 4;
    localparam int REP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0, ena_5hz = 1'b0;
    logic btn_mode = 1'b0, btn_up = 1'b0, btn_dw = 1'b0;

    logic [1:0] mode24, mode12;
    logic [5:0] hour24, min24, sec24, hour12, min12, sec12;
    logic       pm24, pm12;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode and time as seconds-of-day.
    int m_mode = 0;
    int m_t    = 0;

    time_keeper #(.DB_CYCLES(DB), .H24(1), .REPEAT_DELAY(REP)) dut (
        .clk(clk), .rst(rst), .ena(ena), .ena_5hz(ena_5hz),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_dw(btn_dw),
        .select_mode(mode24), .hour(hour24), .min(min24), .sec(sec24), .pm(pm24)
    );

    time_keeper #(.DB_CYCLES(DB), .H24(0), .REPEAT_DELAY(REP)) dut12 (
        .clk(clk), .rst(rst), .ena(ena), .ena_5hz(ena_5hz),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_dw(btn_dw),
        .select_mode(mode12), .hour(hour12), .min(min12), .sec(sec12), .pm(pm12)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int n_ena;
        int exp_h;
        int exp_m;
        int exp_s;
    } vec_t;

    function automatic int f_h(); return m_t / 3600;       endfunction
    function automatic int f_m(); return (m_t / 60) % 60;  endfunction
    function automatic int f_s(); return m_t % 60;         endfunction

    function automatic void set_hms(input int h, input int m, input int s);
        m_t = h * 3600 + m * 60 + s;
    endfunction

    function automatic void model_ena();
        if (m_mode == 0) m_t = (m_t + 1) % 86400;
    endfunction

    function automatic void model_mode();
        m_mode = (m_mode + 1) % 4;
    endfunction

    function automatic void model_step(input int delta);
        int h, m, s;
        h = f_h(); m = f_m(); s = f_s();
        case (m_mode)
            1: h = (h + delta + 24 * 10) % 24;
            2: m = (m + delta + 60 * 10) % 60;
            3: s = (s + delta + 60 * 10) % 60;
            default: ;
        endcase
        set_hms(h, m, s);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int h12;
        h12 = (f_h() % 12 == 0) ? 12 : f_h() % 12;
        check({tag, " mode"},    int'(mode24), m_mode);
        check({tag, " hour"},    int'(hour24), f_h());
        check({tag, " min"},     int'(min24),  f_m());
        check({tag, " sec"},     int'(sec24),  f_s());
        check({tag, " pm24"},    int'(pm24),   0);
        check({tag, " mode12"},  int'(mode12), m_mode);
        check({tag, " hour12"},  int'(hour12), h12);
        check({tag, " min12"},   int'(min12),  f_m());
        check({tag, " sec12"},   int'(sec12),  f_s());
        check({tag, " pm12"},    int'(pm12),   (f_h() >= 12) ? 1 : 0);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic md, input logic up, input logic dw);
        btn_mode = md; btn_up = up; btn_dw = dw;
        cycles(10);
        btn_mode = 1'b0; btn_up = 1'b0; btn_dw = 1'b0;
        cycles(10);
        if (md) model_mode();
        if (up && !dw) model_step(1);
        if (dw && !up) model_step(-1);
    endtask

    task automatic ena_burst(input int n);
        ena = 1'b1;
        cycles(n);
        ena = 1'b0;
        repeat (n) model_ena();
    endtask

    vec_t vecs[4];

    initial begin
        int exp_rep;

        vecs[0] = '{1,    0, 0, 1};
        vecs[1] = '{58,   0, 0, 59};
        vecs[2] = '{1,    0, 1, 0};
        vecs[3] = '{3540, 1, 0, 0};

        // Reset takes effect immediately, before any clock edge.
        #1;
        check_state("reset");
        cycles(2);
        rst = 1'b0;
        cycles(1);

        foreach (vecs[i]) begin
            ena_burst(vecs[i].n_ena);
            check($sformatf("table%0d hour", i), int'(hour24), vecs[i].exp_h);
            check($sformatf("table%0d min", i),  int'(min24),  vecs[i].exp_m);
            check($sformatf("table%0d sec", i),  int'(sec24),  vecs[i].exp_s);
            check($sformatf("table%0d mode", i), int'(mode24), 0);
        end
        check_state("after 3600");

        // Bouncy mode button: 1,0,1,0 then steady high.
        btn_mode = 1'b1; cycles(1);
        btn_mode = 1'b0; cycles(1);
        btn_mode = 1'b1; cycles(1);
        btn_mode = 1'b0; cycles(1);
        btn_mode = 1'b1;
        cycles(6);
        check("debounce edge6 mode", int'(mode24), 0);
        cycles(1);
        check("debounce edge7 mode", int'(mode24), 1);
        cycles(3);
        btn_mode = 1'b0;
        cycles(10);
        model_mode();
        check_state("debounce single press");

        // 12-hour display: h 1 -> 13 -> 0, then 0 down to 23.
        repeat (12) press(1'b0, 1'b1, 1'b0);
        check("h13 hour12", int'(hour12), 1);
        check("h13 pm12",   int'(pm12),   1);
        repeat (11) press(1'b0, 1'b1, 1'b0);
        check("h0 hour12", int'(hour12), 12);
        check("h0 pm12",   int'(pm12),   0);
        press(1'b0, 1'b0, 1'b1);
        check_state("hour down wrap");

        // SET_MIN: 0 down to 59, up back to 0 with hour unchanged.
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check("min down wrap", int'(min24), 59);
        press(1'b0, 1'b1, 1'b0);
        check("min up wrap min",  int'(min24),  0);
        check("min up wrap hour", int'(hour24), 23);
        press(1'b0, 1'b0, 1'b1);

        // SET_SEC: time frozen, then set 58.
        press(1'b1, 1'b0, 1'b0);
        ena_burst(5);
        check_state("frozen in set_sec");
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        check_state("sec set 58");

        // Back to RUN with an ena coinciding with the mode step (edge 7).
        btn_mode = 1'b1;
        cycles(6);
        ena = 1'b1;
        cycles(1);
        ena = 1'b0;
        cycles(3);
        btn_mode = 1'b0;
        cycles(10);
        model_mode();
        check_state("ena on exit ignored");
        ena_burst(2);
        check_state("full carry 23:59:59->0");

        // Auto-repeat in SET_SEC.
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
`ifdef TIME_KEEPER_AUTO_REPEAT_EN
        exp_rep = 5;
`else
        exp_rep = 1;
`endif
        btn_up = 1'b1;
        cycles(10);
        repeat (6) begin
            ena_5hz = 1'b1; cycles(1);
            ena_5hz = 1'b0; cycles(3);
        end
        btn_up = 1'b0;
        cycles(12);
        model_step(exp_rep);
        check_state("hold up repeat");
        btn_up = 1'b1; btn_dw = 1'b1;
        cycles(10);
        repeat (6) begin
            ena_5hz = 1'b1; cycles(1);
            ena_5hz = 1'b0; cycles(3);
        end
        btn_up = 1'b0; btn_dw = 1'b0;
        cycles(12);
        check_state("hold both no change");

        // Randomised operations against the model.
        for (int k = 0; k < 30; k++) begin
            int op;
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    int n;
                    n = $urandom_range(1, 150);
                    for (int c = 0; c < n; c++) begin
                        ena = 1'($urandom_range(0, 1));
                        cycles(1);
                        if (ena) model_ena();
                    end
                    ena = 1'b0;
                end
                1: press(1'b1, 1'b0, 1'b0);
                2: press(1'b0, 1'b1, 1'b0);
                3: press(1'b0, 1'b0, 1'b1);
                default: press(1'b0, 1'b1, 1'b1);
            endcase
            check_state($sformatf("random op%0d type%0d", k, op));
        end

        // Asynchronous reset while in a SET mode.
        if (m_mode == 0) press(1'b1, 1'b0, 1'b0);
        check("pre-reset in set mode", int'(mode24), m_mode);
        #3;
        rst = 1'b1;
        #1;
        m_mode = 0;
        m_t    = 0;
        check_state("async reset from set");
        cycles(2);
        rst = 1'b0;
        cycles(2);
        check_state("after reset release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
